blowfish128_feistel_ctrl: RTL
=============================

Name: blowfish128_feistel_ctrl

Overview:
- Initiator side of the Blowfish-128 F-function handshake.
- Sequences the 16 Feistel rounds over a 128-bit block (two 64-bit halves L/R) for encryption or decryption.
- Per round it drives the F-function's X/Enable, waits for outputValid, and consumes Y.
- Sits between the cipher top level, the P-array subkey store and one blowfish128_ffunc instance; the instance is wired by the integrator, not inside this block.

Parameters:
- ROUNDS, 16, number of Feistel rounds; subkeys used are indices 0..ROUNDS+1.
- IDX_W, 5, width of SubkeyIdx; must satisfy 2^IDX_W > ROUNDS+1.
- F_TIMEOUT, 15, maximum cycles FEnable stays high awaiting FValid before Error.

Ports:
- Clk  in  1  clock; single clock domain.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  begin an operation; accepted only while Busy=0.
- Decrypt  in  1  0=encrypt, 1=decrypt; sampled with Start.
- DataIn  in  128  block; [127:64]=L, [63:0]=R; sampled with Start.
- SubkeyIdx  out  IDX_W  P-array index requested this cycle.
- SubkeyData  in  64  P[SubkeyIdx], combinational, valid in the same cycle.
- FEnable  out  1  level enable to the F-function; low for one cycle clears it.
- FX  out  64  F-function input; held stable while FEnable=1.
- FY  in  64  F-function result.
- FValid  in  1  F-function outputValid.
- DataOut  out  128  result; held until the next accepted Start.
- OutValid  out  1  one-cycle pulse when DataOut is updated.
- Busy  out  1  high from the cycle after Start until the DONE/abort cycle.
- Error  out  1  sticky F-timeout flag; cleared by the next accepted Start.

Behaviour:
- Reset: state=IDLE. All outputs zero: FEnable, FX, DataOut, OutValid, Busy, Error, SubkeyIdx.
- Reset mid-operation aborts the operation with no OutValid. Because FEnable goes low, the F-function also clears. The F-function's RstN is tied to ~Rst at the top level.
- States: IDLE, PRE, FWAIT, UPD, FIN1, FIN2, DONE.
- IDLE: on Start, latch L, R and Decrypt, set r=0, clear Error, go to PRE.
  - Start while Busy is ignored, with no side effects.
- PRE (1 cycle): L <= L ^ SubkeyData. Go to FWAIT.
- FWAIT: FEnable=1, FX=L, timeout counter increments.
  - On FValid=1: capture FY and go to UPD.
  - If the counter reaches F_TIMEOUT first: Error<=1, FEnable<=0, go to IDLE with no OutValid.
- UPD (1 cycle): FEnable=0, which also resets the F-function between rounds. L <= R ^ FY; R <= L; r <= r+1. Go to PRE if r+1<ROUNDS, else to FIN1.
- FIN1 (1 cycle): undo the last swap and whiten. L <= R ^ SubkeyData; R <= L.
- FIN2 (1 cycle): R <= R ^ SubkeyData. Go to DONE.
  - Net result after FIN1/FIN2 (standard Blowfish): R_final = L_loop ^ P[ROUNDS], L_final = R_loop ^ P[ROUNDS+1].
- DONE (1 cycle): DataOut <= {L,R}, OutValid=1, Busy=0 in the same cycle. Go to IDLE.
- SubkeyIdx in PRE: encrypt r; decrypt ROUNDS+1-r.
- SubkeyIdx in FIN1: encrypt ROUNDS+1; decrypt 0.
- SubkeyIdx in FIN2: encrypt ROUNDS; decrypt 1.
- SubkeyIdx in all other states: 0.
- Latency with blowfish128_ffunc:
  - FValid is visible in the 5th FWAIT cycle, so one round = 1+5+1 = 7 cycles.
  - With Start sampled at edge 0, OutValid is high in cycle 7*ROUNDS+3, i.e. 115 for 16 rounds.
  - The controller never counts F latency; it only waits on FValid.
- FValid is ignored outside FWAIT. FY is captured only on the FValid cycle.
- All XORs are 64-bit with no carry. r is a counter of ceil(log2(ROUNDS+1)) bits with no wrap: it terminates at ROUNDS.

Decomposition:
- blowfish128_pkg holds the state encoding, default ROUNDS, IDX_W and the subkey-index mapping function (encrypt/decrypt).
- No sub-module; the FSM and datapath are small. The F-function stays external so a stub can replace it in unit tests.

Test Plan:
- Stub F (FValid 4 cycles after FEnable, FY=0), all subkeys 0, DataIn=128'h0011223344556677_8899AABBCCDDEEFF, encrypt -> DataOut=128'h8899AABBCCDDEEFF_0011223344556677, OutValid in cycle 115.
- Real blowfish128_ffunc with random P-array: encrypt 128'h0123456789ABCDEF_FEDCBA9876543210, then decrypt the result -> original plaintext recovered; SubkeyIdx sequence 0..15,17,16 for encrypt and 17..2,0,1 for decrypt.
- Rst asserted at cycle 50 of an operation -> FEnable=0, Busy=0, Error=0 next cycle; no OutValid; a new Start completes with the correct result.
- Stub never asserts FValid -> Error=1 after 15 FWAIT cycles, FEnable drops, Busy=0, no OutValid; next Start clears Error.
- Start pulses at cycles 10 and 60 during a busy operation -> ignored; single OutValid at 115; DataIn changes after cycle 0 do not affect the result.
- FValid glitch asserted during PRE/UPD -> no state change; FY is not captured.

Source files
------------

// File: rtl/blowfish128_pkg.sv
// Blowfish-128 Feistel controller shared types.
// State encoding, default sizing and the P-array index mapping.
package blowfish128_pkg;

    localparam int ROUNDS_DEF    = 16;
    localparam int IDX_W_DEF     = 5;
    localparam int F_TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_FWAIT,
        S_UPD,
        S_FIN1,
        S_FIN2,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_ROUND,
        K_FIN1,
        K_FIN2
    } key_use_t;

    // Decryption walks the P-array backwards, including the two whitening keys.
    function automatic int subkey_idx(
        key_use_t kind,
        logic     dec,
        int       rnd,
        int       rounds
    );
        int idx;
        idx = 0;
        case (kind)
            K_ROUND: idx = dec ? (rounds + 1 - rnd) : rnd;
            K_FIN1:  idx = dec ? 0 : (rounds + 1);
            K_FIN2:  idx = dec ? 1 : rounds;
            default: idx = 0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/blowfish128_feistel_ctrl.sv
// Blowfish-128 round sequencer: drives an external F-function over a
// valid-level handshake and whitens the block with P-array subkeys.
module blowfish128_feistel_ctrl
    import blowfish128_pkg::*;
#(
    parameter int ROUNDS    = ROUNDS_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int F_TIMEOUT = F_TIMEOUT_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Decrypt,
    input  logic [127:0]     DataIn,
    output logic [IDX_W-1:0] SubkeyIdx,
    input  logic [63:0]      SubkeyData,
    output logic             FEnable,
    output logic [63:0]      FX,
    input  logic [63:0]      FY,
    input  logic             FValid,
    output logic [127:0]     DataOut,
    output logic             OutValid,
    output logic             Busy,
    output logic             Error
);

    localparam int R_W = $clog2(ROUNDS + 1);
    localparam int T_W = $clog2(F_TIMEOUT + 1);

    state_t         state;
    logic [63:0]    lh;
    logic [63:0]    rh;
    logic [63:0]    fy_q;
    logic           dec;
    logic [R_W-1:0] rnd;
    logic [T_W-1:0] tcnt;

    // SubkeyIdx is registered one step ahead so it is stable in the
    // cycle that consumes SubkeyData.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= S_IDLE;
            lh        <= '0;
            rh        <= '0;
            fy_q      <= '0;
            dec       <= 1'b0;
            rnd       <= '0;
            tcnt      <= '0;
            SubkeyIdx <= '0;
            FEnable   <= 1'b0;
            FX        <= '0;
            DataOut   <= '0;
            OutValid  <= 1'b0;
            Busy      <= 1'b0;
            Error     <= 1'b0;
        end else begin
            OutValid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (Start) begin
                        lh        <= DataIn[127:64];
                        rh        <= DataIn[63:0];
                        dec       <= Decrypt;
                        rnd       <= '0;
                        Error     <= 1'b0;
                        Busy      <= 1'b1;
                        SubkeyIdx <= IDX_W'(subkey_idx(K_ROUND, Decrypt, 0, ROUNDS));
                        state     <= S_PRE;
                    end
                end
                S_PRE: begin
                    lh        <= lh ^ SubkeyData;
                    FX        <= lh ^ SubkeyData;
                    FEnable   <= 1'b1;
                    tcnt      <= '0;
                    SubkeyIdx <= '0;
                    state     <= S_FWAIT;
                end
                S_FWAIT: begin
                    if (FValid) begin
                        fy_q    <= FY;
                        FEnable <= 1'b0;
                        state   <= S_UPD;
                    end else if (tcnt == T_W'(F_TIMEOUT - 1)) begin
                        Error   <= 1'b1;
                        FEnable <= 1'b0;
                        Busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + T_W'(1);
                    end
                end
                S_UPD: begin
                    lh  <= rh ^ fy_q;
                    rh  <= lh;
                    rnd <= rnd + R_W'(1);
                    if (int'(rnd) + 1 < ROUNDS) begin
                        SubkeyIdx <= IDX_W'(subkey_idx(K_ROUND, dec, int'(rnd) + 1, ROUNDS));
                        state     <= S_PRE;
                    end else begin
                        SubkeyIdx <= IDX_W'(subkey_idx(K_FIN1, dec, 0, ROUNDS));
                        state     <= S_FIN1;
                    end
                end
                S_FIN1: begin
                    lh        <= rh ^ SubkeyData;
                    rh        <= lh;
                    SubkeyIdx <= IDX_W'(subkey_idx(K_FIN2, dec, 0, ROUNDS));
                    state     <= S_FIN2;
                end
                S_FIN2: begin
                    rh        <= rh ^ SubkeyData;
                    DataOut   <= {lh, rh ^ SubkeyData};
                    OutValid  <= 1'b1;
                    Busy      <= 1'b0;
                    SubkeyIdx <= '0;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
